// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: EX-stage iterative multiply/divide unit owning the
// architectural HI/LO registers. MULT/MULTU/DIV/DIVU take WIDTH iteration
// cycles plus one commit cycle; MTHI/MTLO write in the issuing cycle.
// Build option: define MULDIV_SIGNED_EN for signed MULT/DIV (magnitude
// conversion plus sign fix-up); without it MULT/DIV execute as MULTU/DIVU.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             hiwrite,
   output logic             lowrite,
   output logic [WIDTH-1:0] hi_wdata,
   output logic [WIDTH-1:0] lo_wdata,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [2*WIDTH-1:0] prod_r;      // {partial high, remaining multiplier bits}
   logic [WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   quot_r;      // dividend bits shift out as quotient bits shift in
   logic [WIDTH-1:0]   divisor_r;
   logic               is_div_r;
   logic               busy_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;

   logic               is_mul_op_s;
   logic               is_div_op_s;
   logic [WIDTH-1:0]   rs_mag_s;
   logic [WIDTH-1:0]   rt_mag_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s;
   logic               div_ge_s;
   logic [WIDTH-1:0]   div_diff_s;
   logic [2*WIDTH-1:0] mul_res_s;
   logic [WIDTH-1:0]   quot_res_s;
   logic [WIDTH-1:0]   rem_res_s;
   logic               done_s;
   logic               hiwrite_s;
   logic               lowrite_s;
   logic [WIDTH-1:0]   hi_wdata_s;
   logic [WIDTH-1:0]   lo_wdata_s;

`ifdef MULDIV_SIGNED_EN
   logic               neg_prod_r;
   logic               neg_quot_r;
   logic               neg_rem_r;
   logic               signed_op_s;
   logic               rs_neg_s;
   logic               rt_neg_s;

   // Two's complement negation of a WIDTH-bit value.
   function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction
`endif

   assign is_mul_op_s = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div_op_s = (op == OP_DIV)  || (op == OP_DIVU);

`ifdef MULDIV_SIGNED_EN
   assign signed_op_s = (op == OP_MULT) || (op == OP_DIV);
   assign rs_neg_s    = signed_op_s & rs_val[WIDTH-1];
   assign rt_neg_s    = signed_op_s & rt_val[WIDTH-1];
   assign rs_mag_s    = rs_neg_s ? twos_neg(rs_val) : rs_val;
   assign rt_mag_s    = rt_neg_s ? twos_neg(rt_val) : rt_val;
`else
   assign rs_mag_s    = rs_val;
   assign rt_mag_s    = rt_val;
`endif

   // One shift-add step: add the multiplicand when the current multiplier bit is set.
   assign mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                        {1'b0, (prod_r[0] ? mcand_r : {WIDTH{1'b0}})};
   // One restoring-division step; a zero divisor always "fits", so the
   // remainder collects the dividend and the quotient fills with ones.
   assign div_shift_s = {rem_r, quot_r[WIDTH-1]};
   assign div_ge_s    = (div_shift_s >= {1'b0, divisor_r});
   assign div_diff_s  = div_shift_s[WIDTH-1:0] - divisor_r;

   // Next-state selection; flush always returns the unit to IDLE.
   always_comb begin
      state_nx_s = state_r;
      if (flush) begin
         state_nx_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && is_mul_op_s) begin
                  state_nx_s = ST_MUL;
               end else if (start && is_div_op_s) begin
                  state_nx_s = ST_DIV;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_MUL: begin
               if (cnt_r == CNT_W'(WIDTH - 1)) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_MUL;
               end
            end
            ST_DIV: begin
               if (cnt_r == CNT_W'(WIDTH - 1)) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_DIV;
               end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // State register and registered busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s != ST_IDLE);
      end
   end

   // Operand latch, iteration datapath and iteration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r      <= '0;
         prod_r     <= '0;
         mcand_r    <= '0;
         rem_r      <= '0;
         quot_r     <= '0;
         divisor_r  <= '0;
         is_div_r   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_prod_r <= 1'b0;
         neg_quot_r <= 1'b0;
         neg_rem_r  <= 1'b0;
`endif
      end else if (flush) begin
         cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= '0;
               if (start && (is_mul_op_s || is_div_op_s)) begin
                  mcand_r    <= rs_mag_s;
                  prod_r     <= {{WIDTH{1'b0}}, rt_mag_s};
                  rem_r      <= '0;
                  quot_r     <= rs_mag_s;
                  divisor_r  <= rt_mag_s;
                  is_div_r   <= is_div_op_s;
`ifdef MULDIV_SIGNED_EN
                  // A zero divisor keeps the all-ones quotient unsigned.
                  neg_prod_r <= rs_neg_s ^ rt_neg_s;
                  neg_quot_r <= (rs_neg_s ^ rt_neg_s) && (rt_val != {WIDTH{1'b0}});
                  neg_rem_r  <= rs_neg_s;
`endif
               end
            end
            ST_MUL: begin
               prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
               cnt_r  <= cnt_r + CNT_W'(1);
            end
            ST_DIV: begin
               rem_r  <= div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
               quot_r <= {quot_r[WIDTH-2:0], div_ge_s};
               cnt_r  <= cnt_r + CNT_W'(1);
            end
            ST_DONE: cnt_r <= '0;
            default: cnt_r <= '0;
         endcase
      end
   end

   // Sign fix-up of the raw magnitude results.
   always_comb begin
      mul_res_s  = prod_r;
      quot_res_s = quot_r;
      rem_res_s  = rem_r;
`ifdef MULDIV_SIGNED_EN
      if (neg_prod_r) begin
         mul_res_s = ~prod_r + (2*WIDTH)'(1);
      end else begin
         mul_res_s = prod_r;
      end
      if (neg_quot_r) begin
         quot_res_s = twos_neg(quot_r);
      end else begin
         quot_res_s = quot_r;
      end
      if (neg_rem_r) begin
         rem_res_s = twos_neg(rem_r);
      end else begin
         rem_res_s = rem_r;
      end
`endif
   end

   // Commit strobes and write data; data is forced to zero without a strobe.
   always_comb begin
      done_s     = 1'b0;
      hiwrite_s  = 1'b0;
      lowrite_s  = 1'b0;
      hi_wdata_s = '0;
      lo_wdata_s = '0;
      case (state_r)
         ST_DONE: begin
            if (!flush) begin
               done_s    = 1'b1;
               hiwrite_s = 1'b1;
               lowrite_s = 1'b1;
               if (is_div_r) begin
                  hi_wdata_s = rem_res_s;
                  lo_wdata_s = quot_res_s;
               end else begin
                  hi_wdata_s = mul_res_s[2*WIDTH-1:WIDTH];
                  lo_wdata_s = mul_res_s[WIDTH-1:0];
               end
            end else begin
               done_s = 1'b0;
            end
         end
         ST_IDLE: begin
            if (start && !flush) begin
               if (op == OP_MTHI) begin
                  hiwrite_s  = 1'b1;
                  hi_wdata_s = rs_val;
               end else if (op == OP_MTLO) begin
                  lowrite_s  = 1'b1;
                  lo_wdata_s = rs_val;
               end else begin
                  hiwrite_s = 1'b0;
               end
            end else begin
               hiwrite_s = 1'b0;
            end
         end
         default: done_s = 1'b0;
      endcase
   end

   // Architectural HI/LO registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= '0;
         lo_r <= '0;
      end else begin
         if (hiwrite_s) begin
            hi_r <= hi_wdata_s;
         end
         if (lowrite_s) begin
            lo_r <= lo_wdata_s;
         end
      end
   end

   assign busy     = busy_r;
   assign done     = done_s;
   assign hiwrite  = hiwrite_s;
   assign lowrite  = lowrite_s;
   assign hi_wdata = hi_wdata_s;
   assign lo_wdata = lo_wdata_s;
   assign hi_out   = hi_r;
   assign lo_out   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO writes are queued
// when an operation is issued and popped by a monitor on every write strobe.
// Expected values follow the MULDIV_SIGNED_EN build option.
module tb_hilo_muldiv_unit;
   localparam int W = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MULDIV_SIGNED_EN
   localparam logic [W-1:0] MULT_HI = 32'hFFFFFFFF, MULT_LO = 32'hFFFFFFEB;
   localparam logic [W-1:0] DIV_HI  = 32'hFFFFFFFF, DIV_LO  = 32'hFFFFFFFD;
   localparam logic [W-1:0] OVF_HI  = 32'h00000000, OVF_LO  = 32'h80000000;
   localparam logic [W-1:0] M11_HI  = 32'h00000000, M11_LO  = 32'h00000001;
`else
   localparam logic [W-1:0] MULT_HI = 32'h00000006, MULT_LO = 32'hFFFFFFEB;
   localparam logic [W-1:0] DIV_HI  = 32'h00000001, DIV_LO  = 32'h7FFFFFFC;
   localparam logic [W-1:0] OVF_HI  = 32'h80000000, OVF_LO  = 32'h00000000;
   localparam logic [W-1:0] M11_HI  = 32'hFFFFFFFE, M11_LO  = 32'h00000001;
`endif

   logic         clk = 1'b0;
   logic         rst_n, start, flush;
   logic [2:0]   op;
   logic [W-1:0] rs_val, rt_val;
   logic         busy, done, hiwrite, lowrite;
   logic [W-1:0] hi_wdata, lo_wdata, hi_out, lo_out;

   typedef struct {
      logic         dn;
      logic         hw;
      logic         lw;
      logic [W-1:0] hd;
      logic [W-1:0] ld;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
      .busy(busy), .done(done), .hiwrite(hiwrite), .lowrite(lowrite),
      .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   task automatic push_exp(input logic dn, input logic hw, input logic lw,
                           input logic [W-1:0] hd, input logic [W-1:0] ld);
      exp_t e;
      e.dn = dn; e.hw = hw; e.lw = lw; e.hd = hd; e.ld = ld;
      exp_q.push_back(e);
   endtask

   // Monitor: every strobe the DUT presents must match the next queued write.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (done || hiwrite || lowrite)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {61'd0, done, hiwrite, lowrite}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("strobes", {61'd0, done, hiwrite, lowrite}, {61'd0, mon_e.dn, mon_e.hw, mon_e.lw});
            check("hi_wdata", {32'd0, hi_wdata}, {32'd0, mon_e.hd});
            check("lo_wdata", {32'd0, lo_wdata}, {32'd0, mon_e.ld});
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd7; rs_val = 32'd0; rt_val = 32'd0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      @(negedge clk);
      while (busy === 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check({name, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic run_md(input string name, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
      push_exp(1'b1, 1'b1, 1'b1, eh, el);
      issue(o, a, b);
      wait_idle(name);
      check({name, "_hi"}, {32'd0, hi_out}, {32'd0, eh});
      check({name, "_lo"}, {32'd0, lo_out}, {32'd0, el});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0;
      rs_val = 32'd0; rt_val = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_ctrl", {60'd0, busy, done, hiwrite, lowrite}, 64'd0);
      check("rst_wdata", {hi_wdata, lo_wdata}, 64'd0);
      check("rst_hilo", {hi_out, lo_out}, 64'd0);
      rst_n = 1'b1;

      // MULTU with cycle-exact busy/done timing.
      push_exp(1'b1, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFE);
      issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002);
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         check("busy_timing", {63'd0, busy}, {63'd0, (k <= 33)});
         if (k == 33) check("done_cycle33", {63'd0, done}, 64'd1);
      end
      check("multu_hilo", {hi_out, lo_out}, {32'h00000001, 32'hFFFFFFFE});

      run_md("mult",      OP_MULT, 32'hFFFFFFFD, 32'h00000007, MULT_HI, MULT_LO);
      run_md("mult_m1m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, M11_HI, M11_LO);
      run_md("div",       OP_DIV,  32'hFFFFFFF9, 32'h00000002, DIV_HI, DIV_LO);
      run_md("divu",      OP_DIVU, 32'd100,      32'd7,        32'd2, 32'd14);
      run_md("divu_zero", OP_DIVU, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);
      run_md("div_zero",  OP_DIV,  32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF);
      run_md("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, OVF_HI, OVF_LO);

      // MTHI / MTLO: same-cycle strobe, visible next cycle, never busy.
      push_exp(1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h00000000);
      issue(OP_MTHI, 32'hA5A5A5A5, 32'h00000000);
      @(negedge clk);
      check("mthi_hi", {32'd0, hi_out}, {32'd0, 32'hA5A5A5A5});
      check("mthi_busy", {63'd0, busy}, 64'd0);
      push_exp(1'b0, 1'b0, 1'b1, 32'h00000000, 32'h5A5A0001);
      issue(OP_MTLO, 32'h5A5A0001, 32'h00000000);
      @(negedge clk);
      check("mtlo_hilo", {hi_out, lo_out}, {32'hA5A5A5A5, 32'h5A5A0001});

      // Reserved op does nothing.
      issue(3'd6, 32'h12345678, 32'h00000001);
      @(negedge clk);
      check("rsvd_busy", {63'd0, busy}, 64'd0);
      check("rsvd_hilo", {hi_out, lo_out}, {32'hA5A5A5A5, 32'h5A5A0001});

      // Flush together with MTHI start suppresses the write.
      @(posedge clk); #1;
      start = 1'b1; op = OP_MTHI; rs_val = 32'hDEADBEEF; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd7; rs_val = 32'd0; flush = 1'b0;
      @(negedge clk);
      check("flush_mthi_hi", {32'd0, hi_out}, {32'd0, 32'hA5A5A5A5});

      // Flush a DIVU at cycle 10.
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush10_busy", {63'd0, busy}, 64'd0);
      repeat (40) @(negedge clk);
      check("flush10_hilo", {hi_out, lo_out}, {32'hA5A5A5A5, 32'h5A5A0001});

      // Flush in the DONE cycle suppresses the commit.
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (32) @(posedge clk);
      #1 flush = 1'b1;
      #1 check("flush_done_strobes", {61'd0, done, hiwrite, lowrite}, 64'd0);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush_done_busy", {63'd0, busy}, 64'd0);
      check("flush_done_hilo", {hi_out, lo_out}, {32'hA5A5A5A5, 32'h5A5A0001});

      run_md("divu_after", OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);

      // Asynchronous reset mid-divide clears everything immediately.
      issue(OP_DIVU, 32'h00001234, 32'h00000003);
      repeat (19) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_ctrl", {60'd0, busy, done, hiwrite, lowrite}, 64'd0);
      check("arst_wdata", {hi_wdata, lo_wdata}, 64'd0);
      check("arst_hilo", {hi_out, lo_out}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("arst_after", {31'd0, busy, hi_out}, 64'd0);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
